led_fade_controller: RTL and testbench

LED_FADE_CONTROLLER -- requirements
Module: led_fade_controller

---
 rtl/led_fade_controller_pkg.sv | 30 +++
 rtl/fade_step_timer.sv | 46 ++++
 rtl/led_fade_controller.sv | 135 +++++++++++++
 tb/tb_led_fade_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_controller_pkg.sv
// Shared definitions for the LED fade controller: mode encodings, FSM states
// and the mapping from a state back to the mode it implements.
package led_fade_controller_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STATIC  = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        STATIC,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO,
        BLINK
    } fade_state_e;

    // Mode served by a state; a mismatch with the requested mode means "re-enter".
    function automatic logic [1:0] state_mode(input fade_state_e s);
        case (s)
            IDLE:    return MODE_OFF;
            STATIC:  return MODE_STATIC;
            BLINK:   return MODE_BLINK;
            default: return MODE_BREATHE;
        endcase
    endfunction

endpackage

// File: rtl/fade_step_timer.sv
// PWM phase counter plus step divider: flags each period boundary and emits a
// step tick every max(step_div,1) boundaries.
module fade_step_timer #(
    parameter int PHASE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic [7:0] step_div_i,
    output logic       period_start_o,
    output logic       wrap_o,
    output logic       step_tick_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic [7:0]         div_last;

    always_comb begin
        phase_d        = phase_q + PHASE_W'(1);
        wrap_o         = &phase_q;
        period_start_o = (phase_q == '0);
        div_last       = (step_div_i == 8'd0) ? 8'd0 : step_div_i - 8'd1;
        // >= keeps ticking sanely if step_div shrinks below the running count
        step_tick_o    = wrap_o && (step_cnt_q >= div_last);
        step_cnt_d     = step_cnt_q;
        if (wrap_o) begin
            if (clear_i || step_tick_o) begin
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            step_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: rtl/led_fade_controller.sv
// LED fade controller: OFF / STATIC / BREATHE / BLINK duty sequencer for a
// 4-bit PWM dimmer. Inputs are sampled and duty moves only at period boundaries.
module led_fade_controller
    import led_fade_controller_pkg::*;
#(
    parameter int HOLD_PERIODS = 16,
    parameter int PHASE_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [3:0]  level,
    input  logic [7:0]  step_div,
    output logic [3:0]  duty,
    output logic        period_start,
    output logic        update,
    output logic        busy,
    output fade_state_e dbg_state_o
);

    // The boundary that enters a hold state counts as its first held period.
    localparam int HOLD_LAST = (HOLD_PERIODS > 2) ? HOLD_PERIODS - 2 : 0;
    localparam int HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

    fade_state_e       state_q, state_d;
    logic [3:0]        duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              update_q, update_d;
    logic              wrap, step_tick, clear_step, hold_done;
    logic [1:0]        target;

    fade_step_timer #(
        .PHASE_W(PHASE_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (clear_step),
        .step_div_i    (step_div),
        .period_start_o(period_start),
        .wrap_o        (wrap),
        .step_tick_o   (step_tick)
    );

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        hold_d     = hold_q;
        clear_step = 1'b0;
        target     = en ? mode : MODE_OFF;
        hold_done  = (hold_q == HOLD_W'(HOLD_LAST));
        if (wrap) begin
            if (target != state_mode(state_q)) begin
                // A mode change takes this boundary; any step tick is dropped.
                clear_step = 1'b1;
                case (target)
                    MODE_OFF:     begin state_d = IDLE;   duty_d = '0;    end
                    MODE_STATIC:  begin state_d = STATIC; duty_d = level; end
                    MODE_BREATHE: state_d = (level == 4'd0 && duty_q == 4'd0) ? HOLD_LO : UP;
                    default:      begin state_d = BLINK;  duty_d = level; end
                endcase
            end else begin
                unique case (state_q)
                    IDLE: begin
                        duty_d     = '0;
                        clear_step = 1'b1;
                    end
                    STATIC: duty_d = level;
                    UP: begin
                        if (duty_q > level) begin
                            duty_d  = level;
                            state_d = DOWN;
                        end else begin
                            if (duty_q < level && step_tick) duty_d = duty_q + 4'd1;
                            if (duty_d == level) state_d = (level == 4'd0) ? HOLD_LO : HOLD_HI;
                        end
                    end
                    HOLD_HI: begin
                        if (duty_q > level) begin
                            duty_d  = level;
                            state_d = DOWN;
                        end else if (hold_done) begin
                            state_d = DOWN;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    DOWN: begin
                        if (duty_q > level) duty_d = level;
                        else if (step_tick && duty_q != 4'd0) duty_d = duty_q - 4'd1;
                        if (duty_d == 4'd0) state_d = HOLD_LO;
                    end
                    HOLD_LO: begin
                        if (level != 4'd0) begin
                            if (hold_done) state_d = UP;
                            else hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    BLINK: begin
                        if (step_tick) duty_d = (duty_q != 4'd0) ? 4'd0 : level;
                        else if (duty_q != 4'd0) duty_d = level;
                    end
                    default: begin
                        state_d = IDLE;
                        duty_d  = '0;
                    end
                endcase
            end
            if (state_d != state_q) hold_d = '0;
        end
        update_d = (duty_d != duty_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            hold_q   <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            hold_q   <= hold_d;
            update_q <= update_d;
        end
    end

    always_comb begin
        duty        = duty_q;
        update      = update_q;
        busy        = !(state_q inside {IDLE, STATIC});
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_led_fade_controller.sv
// Bench for led_fade_controller: directed scenarios with constant expectations
// plus randomized input changes checked every cycle against a behavioural model.
module tb_led_fade_controller;
    import led_fade_controller_pkg::*;

    localparam int HOLD   = 2;
    localparam int PERIOD = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  level = 4'd0;
    logic [7:0]  step_div = 8'd1;
    logic [3:0]  duty;
    logic        period_start, update, busy;
    fade_state_e dbg_state;

    always #5 clk = ~clk;

    led_fade_controller #(
        .HOLD_PERIODS(HOLD),
        .PHASE_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .level       (level),
        .step_div    (step_div),
        .duty        (duty),
        .period_start(period_start),
        .update      (update),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_phase = 0;
    fade_state_e m_state = IDLE;
    logic [3:0]  m_duty = 4'd0;
    logic        m_upd = 1'b0;
    int          m_since = 0;      // boundaries since the last step tick
    int          m_hold_left = 0;  // held periods still to go

    function automatic int mode_served(input fade_state_e s);
        if (s == IDLE) return 0;
        if (s == STATIC) return 1;
        if (s == BLINK) return 3;
        return 2;
    endfunction

    task automatic enter_hold(input fade_state_e s);
        m_state     = s;
        m_hold_left = (HOLD > 1) ? HOLD - 1 : 1;
    endtask

    task automatic model_boundary();
        logic [3:0] prev;
        int         tgt;
        int         div;
        bit         tick;
        prev = m_duty;
        tgt  = en ? int'(mode) : 0;
        div  = (step_div == 8'd0) ? 1 : int'(step_div);
        if (tgt != mode_served(m_state)) begin
            m_since = 0;
            case (tgt)
                0: begin m_state = IDLE; m_duty = 4'd0; end
                1: begin m_state = STATIC; m_duty = level; end
                2: if (level == 4'd0 && m_duty == 4'd0) enter_hold(HOLD_LO); else m_state = UP;
                default: begin m_state = BLINK; m_duty = level; end
            endcase
        end else if (tgt == 0) begin
            m_since = 0;
            m_duty  = 4'd0;
        end else begin
            tick    = (m_since + 1 >= div);
            m_since = tick ? 0 : m_since + 1;
            case (m_state)
                STATIC: m_duty = level;
                BLINK: begin
                    if (tick) m_duty = (m_duty != 4'd0) ? 4'd0 : level;
                    else if (m_duty != 4'd0) m_duty = level;
                end
                UP: begin
                    if (m_duty > level) begin
                        m_duty  = level;
                        m_state = DOWN;
                    end else begin
                        if (tick && m_duty < level) m_duty = m_duty + 4'd1;
                        if (m_duty == level) enter_hold((level == 4'd0) ? HOLD_LO : HOLD_HI);
                    end
                end
                HOLD_HI: begin
                    if (m_duty > level) begin
                        m_duty  = level;
                        m_state = DOWN;
                    end else begin
                        m_hold_left--;
                        if (m_hold_left == 0) m_state = DOWN;
                    end
                end
                DOWN: begin
                    if (m_duty > level) m_duty = level;
                    else if (tick && m_duty != 4'd0) m_duty = m_duty - 4'd1;
                    if (m_duty == 4'd0) enter_hold(HOLD_LO);
                end
                default: begin
                    if (level != 4'd0) begin
                        m_hold_left--;
                        if (m_hold_left == 0) m_state = UP;
                    end
                end
            endcase
        end
        m_upd = (m_duty != prev);
    endtask

    task automatic model_edge();
        if (reset) begin
            m_phase = 0; m_state = IDLE; m_duty = 4'd0; m_upd = 1'b0;
            m_since = 0; m_hold_left = 0;
        end else begin
            m_upd = 1'b0;
            if (m_phase == PERIOD - 1) model_boundary();
            m_phase = (m_phase + 1) % PERIOD;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("duty", 32'(duty), 32'(m_duty));
        check("update", 32'(update), 32'(m_upd));
        check("period_start", 32'(period_start), 32'(m_phase == 0));
        check("busy", 32'(busy), 32'(!(m_state inside {IDLE, STATIC})));
        check("state", 32'(dbg_state), 32'(m_state));
    endtask

    task automatic to_boundary();
        for (int i = 0; i < PERIOD; i++) begin
            step_cycle();
            if (m_phase == 0) break;
        end
    endtask

    task automatic expect_seq(input string tag);
        while (exp_q.size() > 0) begin
            to_boundary();
            check(tag, 32'(duty), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic set_in(input logic e, input logic [1:0] m, input logic [3:0] l, input logic [7:0] d);
        en = e; mode = m; level = l; step_div = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset for 2 cycles, then STATIC level 9
        set_in(1'b1, MODE_STATIC, 4'd9, 8'd1);
        reset = 1'b1;
        step_cycle();
        step_cycle();
        reset = 1'b0;
        check("rst_period_start", 32'(period_start), 32'd1);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        to_boundary();
        check("static_duty", 32'(duty), 32'd9);
        check("static_update", 32'(update), 32'd1);
        check("static_busy", 32'(busy), 32'd0);
        step_cycle();
        check("static_update_pulse", 32'(update), 32'd0);

        // BREATHE level 3, step_div 1, starting from IDLE
        set_in(1'b0, MODE_OFF, 4'd3, 8'd1);
        to_boundary();
        check("off_duty", 32'(duty), 32'd0);
        set_in(1'b1, MODE_BREATHE, 4'd3, 8'd1);
        exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        expect_seq("breathe_seq");
        check("breathe_busy", 32'(busy), 32'd1);

        // BLINK level 15 with step_div 0, then step_div 1
        set_in(1'b1, MODE_BLINK, 4'd15, 8'd0);
        exp_q = {4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
        expect_seq("blink_div0");
        step_div = 8'd1;
        exp_q = {4'd15, 4'd0, 4'd15, 4'd0};
        expect_seq("blink_div1");

        // HOLD_HI at 12, level lowered to 5 mid-period
        set_in(1'b1, MODE_BREATHE, 4'd12, 8'd1);
        repeat (13) to_boundary();
        check("hold_hi_duty", 32'(duty), 32'd12);
        check("hold_hi_state", 32'(dbg_state), 32'(HOLD_HI));
        repeat (7) step_cycle();
        level = 4'd5;
        to_boundary();
        check("clamp_duty", 32'(duty), 32'd5);
        check("clamp_state", 32'(dbg_state), 32'(DOWN));
        to_boundary();
        check("clamp_next", 32'(duty), 32'd4);

        // en dropped mid-period during UP at duty 6
        set_in(1'b0, MODE_BREATHE, 4'd12, 8'd1);
        to_boundary();
        en = 1'b1;
        repeat (7) to_boundary();
        check("up6_duty", 32'(duty), 32'd6);
        check("up6_state", 32'(dbg_state), 32'(UP));
        repeat (5) step_cycle();
        en = 1'b0;
        for (int i = 0; i < PERIOD && m_phase != PERIOD - 1; i++) step_cycle();
        check("en_drop_hold", 32'(duty), 32'd6);
        step_cycle();
        check("en_drop_duty", 32'(duty), 32'd0);
        check("en_drop_state", 32'(dbg_state), 32'(IDLE));

        // reset pulsed during DOWN
        set_in(1'b1, MODE_BREATHE, 4'd4, 8'd1);
        repeat (7) to_boundary();
        check("down_duty", 32'(duty), 32'd3);
        check("down_state", 32'(dbg_state), 32'(DOWN));
        repeat (3) step_cycle();
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        check("rst_mid_duty", 32'(duty), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        check("rst_mid_period_start", 32'(period_start), 32'd1);

        // randomized mode/level/divider changes at arbitrary phases
        for (int it = 0; it < 160; it++) begin
            en       = ($urandom_range(0, 7) != 0);
            mode     = 2'($urandom_range(0, 3));
            level    = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step_div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                step_cycle();
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 48)) step_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
